// File: rtl/pipe_pkg.sv
// Shared types and constants for the execution-pipe result forwarding chain.
// Holds the stage entry layout and the default injection map of the even pipe.
package pipe_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              write;
  } fwd_entry_t;

  // Byte u holds the injection stage of unit u: unit0->6, unit1->2, unit2->2, unit3->0.
  localparam logic [31:0] EVEN_UNIT_STAGE = {8'd0, 8'd2, 8'd2, 8'd6};

endpackage

// File: rtl/fwd_lookup.sv
// Priority lookup for one source operand over the forwarding entries.
// Entry 0 is the youngest; the lowest-indexed matching valid entry supplies the value.
module fwd_lookup
  import pipe_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  fwd_entry_t [NUM_ENTRIES-1:0] entries,
  input  logic [ADDR_W-1:0]            src_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  // Scan oldest to youngest so the youngest match is the last one assigned.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].write && (entries[i].addr == src_addr)) begin
        hit  = 1'b1;
        data = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/result_forward_chain.sv
// Result staging and forwarding chain: units inject at fixed stages, entries shift toward
// writeback each cycle, every stage is exported, and source operands look up the youngest value.
module result_forward_chain #(
  parameter int                     NUM_UNITS  = 4,
  parameter int                     DEPTH      = 7,
  parameter int                     DATA_W     = pipe_pkg::DATA_W,
  parameter int                     ADDR_W     = pipe_pkg::ADDR_W,
  parameter int                     NUM_SRC    = 3,
  parameter logic [NUM_UNITS*8-1:0] UNIT_STAGE = pipe_pkg::EVEN_UNIT_STAGE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_UNITS-1:0]        res_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] res_data,
  input  logic [NUM_UNITS*ADDR_W-1:0] res_addr,
  output logic [DEPTH*DATA_W-1:0]     fw_data,
  output logic [DEPTH*ADDR_W-1:0]     fw_addr,
  output logic [DEPTH-1:0]            fw_write,
  output logic [DATA_W-1:0]           wb_data,
  output logic [ADDR_W-1:0]           wb_addr,
  output logic                        wb_write,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  output logic [NUM_SRC-1:0]          src_hit,
  output logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        collision,
  output logic                        overwrite
);
  import pipe_pkg::*;

  if (NUM_UNITS < 1) begin : g_bad_units
    $error("result_forward_chain: NUM_UNITS must be at least 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("result_forward_chain: DEPTH must be at least 1");
  end
  if ((DATA_W != pipe_pkg::DATA_W) || (ADDR_W != pipe_pkg::ADDR_W)) begin : g_bad_width
    $error("result_forward_chain: DATA_W/ADDR_W must match pipe_pkg entry layout");
  end
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_stage_check
    if (int'(UNIT_STAGE[u*8 +: 8]) >= DEPTH) begin : g_bad_stage
      $error("result_forward_chain: UNIT_STAGE of unit %0d is outside the chain", u);
    end
  end

  fwd_entry_t             stage_q    [DEPTH];
  fwd_entry_t             stage_next [DEPTH];
  fwd_entry_t             wb_q;
  logic [DEPTH-1:0]       stage_collide;
  logic [DEPTH-1:0]       stage_displace;
  fwd_entry_t [DEPTH:0]   entries;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    fwd_entry_t           upstream;
    fwd_entry_t           next_e;
    logic [NUM_UNITS-1:0] hits;

    if (s == 0) begin : g_head
      assign upstream = '0;
    end else begin : g_body
      assign upstream = stage_q[s-1];
    end

    // Walking from the highest unit down leaves the lowest-indexed claimant in next_e.
    always_comb begin
      hits   = '0;
      next_e = upstream;
      for (int u = NUM_UNITS - 1; u >= 0; u--) begin
        if (res_valid[u] && (UNIT_STAGE[u*8 +: 8] == 8'(s))) begin
          hits[u]      = 1'b1;
          next_e.data  = res_data[u*DATA_W +: DATA_W];
          next_e.addr  = res_addr[u*ADDR_W +: ADDR_W];
          next_e.write = 1'b1;
        end
      end
    end

    assign stage_next[s]     = next_e;
    assign stage_collide[s]  = (hits & (hits - NUM_UNITS'(1))) != '0;
    assign stage_displace[s] = (|hits) && upstream.write;

    assign fw_data[s*DATA_W +: DATA_W] = stage_q[s].data;
    assign fw_addr[s*ADDR_W +: ADDR_W] = stage_q[s].addr;
    assign fw_write[s]                 = stage_q[s].write;
    assign entries[s]                  = stage_q[s];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
      wb_q      <= '0;
      collision <= 1'b0;
      overwrite <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_next[s];
      end
      wb_q      <= stage_q[DEPTH-1];
      collision <= |stage_collide;
      overwrite <= |stage_displace;
    end
  end

  assign wb_data        = wb_q.data;
  assign wb_addr        = wb_q.addr;
  assign wb_write       = wb_q.write;
  assign entries[DEPTH] = wb_q;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_src
    fwd_lookup #(
      .NUM_ENTRIES(DEPTH + 1)
    ) u_lookup (
      .entries (entries),
      .src_addr(src_addr[p*ADDR_W +: ADDR_W]),
      .hit     (src_hit[p]),
      .data    (src_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_result_forward_chain.sv
// Directed bench for result_forward_chain: expected writebacks go into a scoreboard queue
// and a monitor pops them as wb_write appears; directed checks cover timing and flags.
module tb_result_forward_chain;

  localparam int NUM_UNITS = 4;
  localparam int DEPTH     = 7;
  localparam int DATA_W    = 128;
  localparam int ADDR_W    = 7;
  localparam int NUM_SRC   = 3;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_UNITS-1:0]        res_valid;
  logic [NUM_UNITS*DATA_W-1:0] res_data;
  logic [NUM_UNITS*ADDR_W-1:0] res_addr;
  logic [DEPTH*DATA_W-1:0]     fw_data;
  logic [DEPTH*ADDR_W-1:0]     fw_addr;
  logic [DEPTH-1:0]            fw_write;
  logic [DATA_W-1:0]           wb_data;
  logic [ADDR_W-1:0]           wb_addr;
  logic                        wb_write;
  logic [NUM_SRC*ADDR_W-1:0]   src_addr;
  logic [NUM_SRC-1:0]          src_hit;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic                        collision;
  logic                        overwrite;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_item_t;

  wb_item_t sb[$];
  int       checks = 0;
  int       errors = 0;

  result_forward_chain dut (
    .clk      (clk),
    .reset    (reset),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_addr (res_addr),
    .fw_data  (fw_data),
    .fw_addr  (fw_addr),
    .fw_write (fw_write),
    .wb_data  (wb_data),
    .wb_addr  (wb_addr),
    .wb_write (wb_write),
    .src_addr (src_addr),
    .src_hit  (src_hit),
    .src_data (src_data),
    .collision(collision),
    .overwrite(overwrite)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int u, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    res_valid[u]                  = 1'b1;
    res_addr[u*ADDR_W +: ADDR_W]  = addr;
    res_data[u*DATA_W +: DATA_W]  = data;
  endtask

  task automatic clearStimulus();
    res_valid = '0;
    res_addr  = '0;
    res_data  = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_write === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("wb_unexpected", DATA_W'(wb_write), '0);
      end else begin
        wb_item_t exp_item;
        exp_item = sb.pop_front();
        checkOutput("wb_addr", DATA_W'(wb_addr), DATA_W'(exp_item.addr));
        checkOutput("wb_data", wb_data, exp_item.data);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    src_addr = '0;
    clearStimulus();
    for (int u = 0; u < NUM_UNITS; u++) applyStimulus(u, ADDR_W'(u + 1), DATA_W'(u + 100));
    tick(2);
    checkOutput("rst_fw_write", DATA_W'(fw_write), '0);
    checkOutput("rst_wb_write", DATA_W'(wb_write), '0);
    checkOutput("rst_collision", DATA_W'(collision), '0);
    checkOutput("rst_overwrite", DATA_W'(overwrite), '0);
    reset = 1'b0;
    clearStimulus();
    tick(1);

    // Latency through the full chain from stage 0.
    applyStimulus(3, 7'd5, 128'hA5);
    sb.push_back('{addr: 7'd5, data: 128'hA5});
    tick(1);
    clearStimulus();
    checkOutput("lat_fw_write0", DATA_W'(fw_write), DATA_W'(7'b0000001));
    checkOutput("lat_fw_addr0", DATA_W'(fw_addr[0 +: ADDR_W]), DATA_W'(7'd5));
    checkOutput("lat_fw_data0", fw_data[0 +: DATA_W], 128'hA5);
    tick(6);
    checkOutput("lat_fw_write6", DATA_W'(fw_write), DATA_W'(7'b1000000));
    checkOutput("lat_fw_addr6", DATA_W'(fw_addr[6*ADDR_W +: ADDR_W]), DATA_W'(7'd5));
    tick(1);
    checkOutput("lat_wb_write", DATA_W'(wb_write), DATA_W'(1'b1));
    checkOutput("lat_fw_empty", DATA_W'(fw_write), '0);

    // Two units on stage 2 in the same cycle: unit1 wins, unit2 is dropped.
    applyStimulus(1, 7'd9, 128'h99);
    applyStimulus(2, 7'd10, 128'h1010);
    sb.push_back('{addr: 7'd9, data: 128'h99});
    tick(1);
    clearStimulus();
    checkOutput("col_fw_write", DATA_W'(fw_write), DATA_W'(7'b0000100));
    checkOutput("col_fw_addr2", DATA_W'(fw_addr[2*ADDR_W +: ADDR_W]), DATA_W'(7'd9));
    checkOutput("col_fw_data2", fw_data[2*DATA_W +: DATA_W], 128'h99);
    checkOutput("col_flag", DATA_W'(collision), DATA_W'(1'b1));
    checkOutput("col_no_ovw", DATA_W'(overwrite), '0);
    tick(1);
    checkOutput("col_flag_clear", DATA_W'(collision), '0);
    tick(6);
    checkOutput("col_sb_drained", DATA_W'(sb.size()), '0);

    // Stage-2 injection displaces an entry sitting in stage 1.
    applyStimulus(3, 7'd3, 128'h33);
    tick(1);
    clearStimulus();
    tick(1);
    applyStimulus(1, 7'd4, 128'h44);
    sb.push_back('{addr: 7'd4, data: 128'h44});
    tick(1);
    clearStimulus();
    checkOutput("ovw_fw_write", DATA_W'(fw_write), DATA_W'(7'b0000100));
    checkOutput("ovw_fw_addr2", DATA_W'(fw_addr[2*ADDR_W +: ADDR_W]), DATA_W'(7'd4));
    checkOutput("ovw_flag", DATA_W'(overwrite), DATA_W'(1'b1));
    checkOutput("ovw_no_col", DATA_W'(collision), '0);
    tick(1);
    checkOutput("ovw_flag_clear", DATA_W'(overwrite), '0);
    tick(6);
    checkOutput("ovw_sb_drained", DATA_W'(sb.size()), '0);

    // Same-cycle inputs are invisible to the lookup.
    src_addr[2*ADDR_W +: ADDR_W] = 7'h60;
    applyStimulus(3, 7'h60, 128'h60);
    #1;
    checkOutput("lk_same_cycle_hit", DATA_W'(src_hit[2]), '0);
    checkOutput("lk_same_cycle_data", src_data[2*DATA_W +: DATA_W], '0);
    clearStimulus();

    // Two copies of addr 7: youngest must win, then wb serves it once the chain is empty.
    applyStimulus(3, 7'd7, 128'd1);
    sb.push_back('{addr: 7'd7, data: 128'd1});
    tick(1);
    clearStimulus();
    tick(3);
    applyStimulus(3, 7'd7, 128'd2);
    sb.push_back('{addr: 7'd7, data: 128'd2});
    tick(1);
    clearStimulus();
    tick(1);
    src_addr[0*ADDR_W +: ADDR_W] = 7'd7;
    src_addr[1*ADDR_W +: ADDR_W] = 7'h55;
    #1;
    checkOutput("lk_fw_addr5", DATA_W'(fw_addr[5*ADDR_W +: ADDR_W]), DATA_W'(7'd7));
    checkOutput("lk_fw_addr1", DATA_W'(fw_addr[1*ADDR_W +: ADDR_W]), DATA_W'(7'd7));
    checkOutput("lk_young_hit", DATA_W'(src_hit[0]), DATA_W'(1'b1));
    checkOutput("lk_young_data", src_data[0 +: DATA_W], 128'd2);
    checkOutput("lk_miss_hit", DATA_W'(src_hit[1]), '0);
    checkOutput("lk_miss_data", src_data[DATA_W +: DATA_W], '0);
    tick(2);
    checkOutput("lk_wb_old_data", wb_data, 128'd1);
    checkOutput("lk_chain_over_wb", src_data[0 +: DATA_W], 128'd2);
    tick(4);
    checkOutput("lk_wb_only_fw", DATA_W'(fw_write), '0);
    checkOutput("lk_wb_only_hit", DATA_W'(src_hit[0]), DATA_W'(1'b1));
    checkOutput("lk_wb_only_data", src_data[0 +: DATA_W], 128'd2);
    tick(1);
    checkOutput("lk_drained_hit", DATA_W'(src_hit[0]), '0);

    // Back-to-back stage-0 injections stream out one per cycle.
    for (int k = 0; k < 27; k++) begin
      if (k < 20) begin
        applyStimulus(3, ADDR_W'(k + 20), DATA_W'(k * 3 + 1));
        sb.push_back('{addr: ADDR_W'(k + 20), data: DATA_W'(k * 3 + 1)});
      end
      tick(1);
      clearStimulus();
      checkOutput("thr_collision", DATA_W'(collision), '0);
      checkOutput("thr_overwrite", DATA_W'(overwrite), '0);
      if (k >= 7) checkOutput("thr_wb_write", DATA_W'(wb_write), DATA_W'(1'b1));
    end
    tick(1);
    checkOutput("thr_wb_end", DATA_W'(wb_write), '0);
    checkOutput("thr_sb_drained", DATA_W'(sb.size()), '0);

    // Reset in mid-flight discards the entry; the monitor flags any later writeback.
    applyStimulus(3, 7'h2A, 128'h2A);
    tick(1);
    clearStimulus();
    tick(2);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_mid_fw_write", DATA_W'(fw_write), '0);
    checkOutput("rst_mid_wb_write", DATA_W'(wb_write), '0);
    reset = 1'b0;
    tick(10);
    checkOutput("rst_mid_sb", DATA_W'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
